// File: rtl/ks_restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// the sizing helper for the iteration counter.
package ks_restoring_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width is ceil(log2(width)), never narrower than one bit.
   function automatic int cnt_bits(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/ks_subtractor.sv
// Combinational Kogge-Stone subtractor: diff = a - b computed as a + ~b + 1
// with a log-depth generate/propagate prefix tree. borrow_n is the carry-out,
// so a borrow happened exactly when borrow_n is low.
module ks_subtractor
   import ks_restoring_divider_pkg::*;
#(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow_n
);

   logic [N-1:0] b_inv;
   logic [N-1:0] gen0;
   logic [N-1:0] prop0;
   logic [N-1:0] gen_cur;
   logic [N-1:0] prop_cur;
   logic [N-1:0] gen_nxt;
   logic [N-1:0] prop_nxt;

   // Prefix tree: the carry-in of 1 is folded into bit 0's generate, then each
   // level doubles the span combined by the black cells.
   always_comb begin
      b_inv    = ~b;
      gen0     = a & b_inv;
      prop0    = a ^ b_inv;
      gen_cur  = gen0;
      gen_cur[0] = gen0[0] | prop0[0];
      prop_cur = prop0;
      gen_nxt  = gen_cur;
      prop_nxt = prop_cur;
      for (int d = 1; d < N; d = d * 2) begin
         gen_nxt  = gen_cur;
         prop_nxt = prop_cur;
         for (int i = d; i < N; i++) begin
            gen_nxt[i]  = gen_cur[i] | (prop_cur[i] & gen_cur[i-d]);
            prop_nxt[i] = prop_cur[i] & prop_cur[i-d];
         end
         gen_cur  = gen_nxt;
         prop_cur = prop_nxt;
      end
      diff     = prop0 ^ {gen_cur[N-2:0], 1'b1};
      borrow_n = gen_cur[N-1];
   end

endmodule

// File: rtl/ks_restoring_divider.sv
// Sequential radix-2 restoring divider producing one quotient bit per clock.
// Valid/ready handshakes on both sides; divide-by-zero returns all-ones
// quotient and the dividend as remainder with div_by_zero flagged.
module ks_restoring_divider
   import ks_restoring_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_bits(WIDTH);

   state_t           state;
   state_t           next_state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   part_rem;
   logic [WIDTH-1:0] quo_sr;
   logic [WIDTH-1:0] div_reg;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             borrow_n;
   logic [WIDTH:0]   next_rem;
   logic [WIDTH-1:0] next_quo;
   logic             accept;
   logic             last_iter;
   logic             unused_rem_msb;

   assign accept    = in_valid & in_ready;
   assign last_iter = (cnt == CW'(WIDTH - 1));

   // The remainder stays below the divisor, so the partial remainder's top
   // bit is only ever a scratch bit of the trial subtraction.
   assign unused_rem_msb = part_rem[WIDTH];

   assign trial    = {part_rem[WIDTH-1:0], quo_sr[WIDTH-1]};
   assign next_rem = borrow_n ? diff : trial;
   assign next_quo = {quo_sr[WIDTH-2:0], borrow_n};

   ks_subtractor #(.N(WIDTH + 1)) u_sub (
      .a        (trial),
      .b        ({1'b0, div_reg}),
      .diff     (diff),
      .borrow_n (borrow_n)
   );

   // State register; reset aborts any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic: zero divisors skip straight to DONE, CALC runs WIDTH cycles.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = (divisor == '0) ? DONE : CALC;
         CALC: if (last_iter) next_state = DONE;
         DONE: if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath: capture operands on accept, shift/subtract in CALC, and load the
   // result registers only when entering DONE so they hold steady while valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         part_rem    <= '0;
         quo_sr      <= '0;
         div_reg     <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt      <= '0;
                  part_rem <= '0;
                  quo_sr   <= dividend;
                  div_reg  <= divisor;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               part_rem <= next_rem;
               quo_sr   <= next_quo;
               cnt      <= cnt + 1'b1;
               if (last_iter) begin
                  quotient    <= next_quo;
                  remainder   <= next_rem[WIDTH-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ks_restoring_divider.sv
// Directed bench for ks_restoring_divider at WIDTH=8: latency, corner operands,
// divide-by-zero, backpressure, mid-operation reset and a reference-model sweep.
module tb_ks_restoring_divider;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks;
   int passes;

   ks_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Present an operation at the current negedge; returns at the negedge after
   // the accept edge, which is cycle 1 relative to the accept.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Step negedges until out_valid, reporting the cycle number it was seen at.
   task automatic wait_valid(output int cyc, output bit timeout);
      cyc = 1;
      while (!out_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      timeout = !out_valid;
   endtask

   // Accept the result for one edge.
   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("[TB] FAIL reset_handshake: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      else passes++;
      checks++;
      if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0)
         $display("[TB] FAIL reset_outputs: got q=%0d r=%0d dbz=%b expected 0/0/0", quotient, remainder, div_by_zero);
      else passes++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int cyc;
      bit to;
      issue(8'd200, 8'd7);
      checks++;
      if (in_ready !== 1'b0)
         $display("[TB] FAIL basic_busy: got in_ready=%b expected 0", in_ready);
      else passes++;
      wait_valid(cyc, to);
      checks++;
      if (to || cyc != 9)
         $display("[TB] FAIL basic_latency: got cycle %0d (timeout=%0d) expected 9", cyc, to);
      else passes++;
      checks++;
      if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0)
         $display("[TB] FAIL basic_result: got q=%0d r=%0d dbz=%b expected 28/4/0", quotient, remainder, div_by_zero);
      else passes++;
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("[TB] FAIL basic_consume: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      else passes++;
   endtask

   task automatic test_extremes();
      int cyc;
      bit to;
      issue(8'd255, 8'd1);
      wait_valid(cyc, to);
      checks++;
      if (to || quotient !== 8'd255 || remainder !== 8'd0 || div_by_zero !== 1'b0)
         $display("[TB] FAIL div_by_one: got q=%0d r=%0d dbz=%b timeout=%0d expected 255/0/0", quotient, remainder, div_by_zero, to);
      else passes++;
      consume();
      issue(8'd5, 8'd200);
      wait_valid(cyc, to);
      checks++;
      if (to || quotient !== 8'd0 || remainder !== 8'd5 || div_by_zero !== 1'b0)
         $display("[TB] FAIL small_dividend: got q=%0d r=%0d dbz=%b timeout=%0d expected 0/5/0", quotient, remainder, div_by_zero, to);
      else passes++;
      consume();
   endtask

   task automatic test_div_zero();
      int cyc;
      bit to;
      issue(8'd77, 8'd0);
      wait_valid(cyc, to);
      checks++;
      if (to || cyc != 1)
         $display("[TB] FAIL dbz_latency: got cycle %0d (timeout=%0d) expected 1", cyc, to);
      else passes++;
      checks++;
      if (quotient !== 8'hFF || remainder !== 8'd77 || div_by_zero !== 1'b1)
         $display("[TB] FAIL dbz_result: got q=%0d r=%0d dbz=%b expected 255/77/1", quotient, remainder, div_by_zero);
      else passes++;
      consume();
      checks++;
      if (out_valid !== 1'b0 || quotient !== 8'hFF || remainder !== 8'd77)
         $display("[TB] FAIL dbz_hold_idle: got out_valid=%b q=%0d r=%0d expected 0/255/77", out_valid, quotient, remainder);
      else passes++;
   endtask

   task automatic test_backpressure();
      int cyc;
      bit to;
      bit stable;
      issue(8'd200, 8'd7);
      wait_valid(cyc, to);
      dividend = 8'd100;
      divisor  = 8'd3;
      in_valid = 1'b1;
      stable   = !to;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4)
            stable = 1'b0;
      end
      checks++;
      if (!stable)
         $display("[TB] FAIL bp_hold: got out_valid=%b in_ready=%b q=%0d r=%0d expected 1/0/28/4", out_valid, in_ready, quotient, remainder);
      else passes++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd28)
         $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b q=%0d expected 0/1/28", out_valid, in_ready, quotient);
      else passes++;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0)
         $display("[TB] FAIL bp_pending_accept: got in_ready=%b expected 0", in_ready);
      else passes++;
      wait_valid(cyc, to);
      checks++;
      if (to || cyc != 9 || quotient !== 8'd33 || remainder !== 8'd1 || div_by_zero !== 1'b0)
         $display("[TB] FAIL bp_next_result: got cycle %0d q=%0d r=%0d dbz=%b expected 9/33/1/0", cyc, quotient, remainder, div_by_zero);
      else passes++;
      consume();
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit to;
      bit quiet;
      issue(8'd250, 8'd3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0)
         $display("[TB] FAIL midrst_state: got in_ready=%b out_valid=%b q=%0d r=%0d expected 1/0/0/0", in_ready, out_valid, quotient, remainder);
      else passes++;
      quiet = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (!quiet)
         $display("[TB] FAIL midrst_discard: got out_valid=1 expected 0");
      else passes++;
      issue(8'd100, 8'd10);
      wait_valid(cyc, to);
      checks++;
      if (to || cyc != 9 || quotient !== 8'd10 || remainder !== 8'd0)
         $display("[TB] FAIL midrst_next: got cycle %0d q=%0d r=%0d expected 9/10/0", cyc, quotient, remainder);
      else passes++;
      consume();
   endtask

   // One operation with random output backpressure, checked against a / b.
   task automatic sweep_one(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_r;
      logic         exp_z;
      bit checked;
      bit consumed;
      int guard;
      exp_q = (b == 0) ? 8'hFF : a / b;
      exp_r = (b == 0) ? a : a % b;
      exp_z = (b == 0);
      issue(a, b);
      checked  = 1'b0;
      consumed = 1'b0;
      guard    = 0;
      while (!consumed && guard < 60) begin
         if (out_valid && !checked) begin
            checked = 1'b1;
            checks++;
            if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_z)
               $display("[TB] FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%b expected %0d/%0d/%b",
                        a, b, quotient, remainder, div_by_zero, exp_q, exp_r, exp_z);
            else passes++;
         end
         out_ready = 1'($urandom_range(0, 1));
         consumed  = out_valid && out_ready;
         @(negedge clk);
         guard++;
      end
      out_ready = 1'b0;
      if (!consumed) begin
         checks++;
         $display("[TB] FAIL sweep_timeout %0d/%0d: got no completed handshake expected one", a, b);
      end
   endtask

   task automatic test_sweep();
      logic [W-1:0] corners [6];
      corners = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd255};
      foreach (corners[i])
         foreach (corners[j])
            sweep_one(corners[i], corners[j]);
      for (int n = 0; n < 1500; n++)
         sweep_one(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks    = 0;
      passes    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
